// File: rtl/fetch_stage.sv
// Instruction fetch stage with the IF/ID pipeline register.
// The PC advances one word per completed memory response. A one-entry hold
// buffer keeps a response that arrives while decode is stalled. A redirect
// flushes IF/ID, and when it arrives with a request still waiting, the
// eventual response is dropped.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | one dead cycle after reset before the first request
// ST_REQ  | request to imem at pc, capture response into IF/ID
// ST_HOLD | response parked in hold buffer while decode stalls, no request
// ST_DROP | request at req_addr still pending, its response will be discarded
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_instr,
   output logic [5:0]  if_opcode,
   output logic [31:0] if_pc4,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] pc_nxt;
   logic [31:0] req_addr;
   logic [31:0] req_addr_nxt;
   logic [31:0] hold_instr;
   logic [31:0] hold_instr_nxt;
   logic [31:0] hold_pc4;
   logic [31:0] hold_pc4_nxt;
   logic [31:0] if_instr_nxt;
   logic [31:0] if_pc4_nxt;
   logic        if_valid_nxt;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_target;

   assign pc_plus4        = pc + 32'd4;
   assign redirect_target = {redirect_pc[31:2], 2'b00};

   // A dropped request keeps presenting its original address until it completes.
   assign imem_addr = (state == ST_DROP) ? req_addr : pc;
   assign if_opcode = if_instr[31:26];

   // Next-state and register-update decisions for the fetch controller.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      req_addr_nxt   = req_addr;
      hold_instr_nxt = hold_instr;
      hold_pc4_nxt   = hold_pc4;
      if_instr_nxt   = if_instr;
      if_pc4_nxt     = if_pc4;
      if_valid_nxt   = if_valid;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_REQ;
         end

         ST_REQ: begin
            req_addr_nxt = pc;
            if (redirect) begin
               pc_nxt       = redirect_target;
               if_instr_nxt = 32'd0;
               if_valid_nxt = 1'b0;
               if (!imem_ready) begin
                  state_nxt = ST_DROP;
               end
            end else if (imem_ready && !stall) begin
               if_instr_nxt = imem_rdata;
               if_pc4_nxt   = pc_plus4;
               if_valid_nxt = 1'b1;
               pc_nxt       = pc_plus4;
            end else if (imem_ready) begin
               hold_instr_nxt = imem_rdata;
               hold_pc4_nxt   = pc_plus4;
               pc_nxt         = pc_plus4;
               state_nxt      = ST_HOLD;
            end else if (!stall) begin
               if_instr_nxt = 32'd0;
               if_valid_nxt = 1'b0;
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               pc_nxt         = redirect_target;
               if_instr_nxt   = 32'd0;
               if_valid_nxt   = 1'b0;
               hold_instr_nxt = 32'd0;
               hold_pc4_nxt   = 32'd0;
               state_nxt      = ST_REQ;
            end else if (!stall) begin
               if_instr_nxt = hold_instr;
               if_pc4_nxt   = hold_pc4;
               if_valid_nxt = 1'b1;
               state_nxt    = ST_REQ;
            end
         end

         ST_DROP: begin
            if (redirect) begin
               pc_nxt = redirect_target;
            end
            if (redirect || !stall) begin
               if_instr_nxt = 32'd0;
               if_valid_nxt = 1'b0;
            end
            if (imem_ready) begin
               state_nxt = ST_REQ;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, PC, hold buffer and IF/ID registers; request flag follows next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         hold_instr <= 32'd0;
         hold_pc4   <= 32'd0;
         if_instr   <= 32'd0;
         if_pc4     <= 32'd0;
         if_valid   <= 1'b0;
         imem_req   <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         req_addr   <= req_addr_nxt;
         hold_instr <= hold_instr_nxt;
         hold_pc4   <= hold_pc4_nxt;
         if_instr   <= if_instr_nxt;
         if_pc4     <= if_pc4_nxt;
         if_valid   <= if_valid_nxt;
         imem_req   <= (state_nxt == ST_REQ) || (state_nxt == ST_DROP);
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts the
// ordered stream of instructions decode should receive, and a monitor pops
// and compares each time decode accepts a valid IF/ID entry.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic [31:0] if_instr;
   logic [5:0]  if_opcode;
   logic [31:0] if_pc4;
   logic        if_valid;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .if_instr   (if_instr),
      .if_opcode  (if_opcode),
      .if_pc4     (if_pc4),
      .if_valid   (if_valid)
   );

   // Instruction memory contents: addr<<4 with address bits folded into the opcode.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 4) ^ {a[9:4], 26'h0};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } sb_item_t;

   sb_item_t sb[$];

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: fetch pointer plus flags for start-up, parked word, dropped request.
   bit          m_startup;
   bit          m_waiting;
   bit          m_dropping;
   logic [31:0] m_pc;
   logic [31:0] m_drop_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_startup   = 1'b1;
      m_waiting   = 1'b0;
      m_dropping  = 1'b0;
      m_pc        = RESET_PC;
      m_drop_addr = RESET_PC;
      sb.delete();
   endtask

   // Applies the effect of the edge just taken, using the inputs that were driven for it.
   task automatic model_edge();
      logic [31:0] tgt;
      sb_item_t    it;
      tgt = redirect_pc & 32'hFFFF_FFFC;
      if (m_startup) begin
         m_startup = 1'b0;
      end else if (m_waiting) begin
         if (redirect) begin
            m_pc      = tgt;
            m_waiting = 1'b0;
            sb.delete();
         end else if (!stall) begin
            m_waiting = 1'b0;
         end
      end else if (m_dropping) begin
         if (redirect) begin
            m_pc = tgt;
            sb.delete();
         end
         if (imem_ready) m_dropping = 1'b0;
      end else begin
         if (redirect) begin
            sb.delete();
            if (!imem_ready) begin
               m_dropping  = 1'b1;
               m_drop_addr = m_pc;
            end
            m_pc = tgt;
         end else if (imem_ready) begin
            it.instr = mem_word(m_pc);
            it.pc4   = m_pc + 32'd4;
            sb.push_back(it);
            m_pc = m_pc + 32'd4;
            if (stall) m_waiting = 1'b1;
         end
      end
   endtask

   task automatic step(input logic rdy, input logic stl, input logic rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      model_edge();
      imem_ready  = rdy;
      stall       = stl;
      redirect    = rd;
      redirect_pc = rpc;
   endtask

   task automatic reset_checks();
      check("rst_imem_req",  {31'd0, imem_req}, 32'd0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_if_instr",  if_instr, 32'd0);
      check("rst_if_pc4",    if_pc4, 32'd0);
      check("rst_if_valid",  {31'd0, if_valid}, 32'd0);
      check("rst_if_opcode", {26'd0, if_opcode}, 32'd0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs are checked before any clock edge.
   task automatic pulse_reset();
      #2;
      reset = 1'b1;
      #1;
      reset_checks();
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   // Monitor: request handshake every cycle, and instruction delivery whenever decode accepts.
   always @(negedge clk) begin
      sb_item_t it;
      if (!reset) begin
         check("imem_req", {31'd0, imem_req}, {31'd0, (!m_startup && !m_waiting)});
         if (!m_startup && !m_waiting)
            check("imem_addr", imem_addr, m_dropping ? m_drop_addr : m_pc);
         if (if_valid === 1'b1 && stall === 1'b0) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_instr: got %h pc4 %h with none expected at %0t",
                        if_instr, if_pc4, $time);
            end else begin
               it = sb.pop_front();
               check("if_instr",  if_instr, it.instr);
               check("if_pc4",    if_pc4, it.pc4);
               check("if_opcode", {26'd0, if_opcode}, {26'd0, it.instr[31:26]});
            end
         end
      end
   end

   initial begin
      logic [31:0] rpc;
      logic        rdy;
      logic        stl;
      logic        rd;

      model_reset();
      imem_ready = 1'b1;
      #1;
      reset_checks();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;

      // straight-line fetch, zero wait
      repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0);
      // stall for three cycles while responses arrive
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
      // redirect together with ready
      step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
      // redirect during a two-cycle wait state
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);
      // redirect while stalled still flushes
      step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
      // pc wrap and unaligned redirect target
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
      // async reset while a request waits
      step(1'b0, 1'b0, 1'b0, 32'd0);
      pulse_reset();
      // async reset while parked in HOLD
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      pulse_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(0, 9) < 7);
         stl = ($urandom_range(0, 9) < 3);
         rd  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = $urandom;
            1:       rpc = $urandom_range(0, 4095);
            2:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            default: rpc = 32'h0000_0100 + $urandom_range(0, 63);
         endcase
         step(rdy, stl, rd, rpc);
         if (i % 700 == 350) pulse_reset();
      end

      // drain: decode accepts everything still in flight
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      #1;
      check("drain_empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register feeding the control unit and register file of the MIPS datapath. It holds the program counter and issues word reads to instruction memory over a req/ready handshake. It captures each returned instruction into the IF/ID register, whose opcode field (bits 31:26) drives the control unit directly. It supports decode-stage stalls, taken-branch redirects that flush the IF/ID register, and a one-entry hold buffer so a memory response arriving during a stall is never lost.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low two bits must be 0).

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode stage cannot accept a new instruction; hold IF/ID and PC.
- redirect  in  1  taken branch/jump resolved this cycle.
- redirect_pc  in  32  new PC; bits 1:0 ignored (forced to 00).
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  byte address of the request (= pc).
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- if_instr  out  32  IF/ID instruction register.
- if_opcode  out  6  if_instr[31:26]; to control unit.
- if_pc4  out  32  address of if_instr plus 4.
- if_valid  out  1  if_instr holds a real instruction (0 = bubble).

## Operation
- States: IDLE, REQ, HOLD, DROP. Registers: pc, hold_instr, hold_pc4, IF/ID (if_instr, if_pc4, if_valid).
- Reset (async, any time, including mid-request): state=IDLE, pc=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, hold regs=0, imem_req=0. Any outstanding memory response is abandoned.
- IDLE: imem_req=0; next state REQ unconditionally.
- REQ: imem_req=1, imem_addr=pc. Priority per edge:
  - redirect: pc<=redirect_pc&~3, if_instr<=0, if_valid<=0. If imem_ready=0, go to DROP, else stay in REQ (the response is discarded).
  - imem_ready & !stall: if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4; stay in REQ.
  - imem_ready & stall: hold_instr<=imem_rdata, hold_pc4<=pc+4, pc<=pc+4; go to HOLD; IF/ID unchanged.
  - !imem_ready & !stall: if_instr<=0, if_valid<=0 (bubble); IF/ID pc4 unchanged.
  - !imem_ready & stall: IF/ID unchanged.
- HOLD: imem_req=0.
  - redirect: pc<=redirect_pc&~3, flush IF/ID, drop the hold buffer, go to REQ.
  - !stall: if_instr<=hold_instr, if_pc4<=hold_pc4, if_valid<=1, go to REQ.
  - stall: remain in HOLD.
- DROP: imem_req=1 with the old address held stable (the address is latched at request start and is not pc). On imem_ready, discard data and go to REQ. A further redirect in DROP updates pc only. IF/ID stays bubble unless stall.
- imem_addr and imem_req are stable while a request waits (handshake rule). The address is latched in a separate req_addr register.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- redirect overrides stall; stall never blocks a flush.

## Timing
- imem_req first asserts the first cycle after reset deasserts, plus one IDLE cycle.
- With imem_ready tied high: one instruction per clock. if_instr updates on the edge ending the ready cycle. if_opcode is combinational from if_instr (zero added latency).
- Redirect penalty with a zero-wait memory: one bubble. The instruction at redirect_pc appears in IF/ID two edges after redirect is sampled.
- All outputs are registered except if_opcode and imem_addr, which are a direct register mux.

## Test plan
- Reset, RESET_PC=0, imem_ready=1, memory returns addr<<4: imem_addr sequence 0,4,8. if_instr=0x0,0x40,0x80. if_pc4=4,8,12. if_valid=1 from the second edge.
- Stall for 3 cycles while a response arrives: state goes to HOLD and imem_req drops. IF/ID stays constant. After release, the held word appears with correct if_pc4, and no instruction is lost or duplicated.
- Redirect to 0x100 on the same cycle as imem_ready: the response is discarded. if_valid=0 for one cycle, then if_instr=mem[0x100] with if_pc4=0x104.
- Redirect during a wait-state (imem_ready low for 2 cycles): imem_addr holds the old address until ready. That data is dropped, then the request goes to redirect_pc. Redirect with stall=1 still flushes IF/ID.
- Async reset mid-request and in HOLD: outputs go to zero and pc to RESET_PC immediately, without waiting for a clock edge. Fetch restarts via IDLE.
- PC wrap: redirect_pc=32'hFFFF_FFFC → next imem_addr=0. if_pc4=0 for that instruction. redirect_pc=0x103 → fetch at 0x100.
